thread_scheduler_rr: RTL and testbench
======================================

// Module: thread_scheduler_rr
// PURPOSE
// - Per-core thread scheduler for the md5crypt CPU; successor to the single look-ahead-pointer scheduler.
// - Takes a full per-thread ready vector (thread_state == WR_RDY) plus an enable mask.
// - Picks the next runnable thread in one cycle with a round-robin priority search.
// - Adds sync reset, non-power-of-2 thread counts, configurable same-thread hold-off and a saturating stall counter.
// PARAMETERS
// - N_THREADS      16  threads per core, >=2, any value (need not be a power of 2)
// - N_THREADS_MSB  `MSB(N_THREADS-1)  MSB of a thread number
// - TS_DELAY       2   cycles of continuous suspension before the current thread may be re-picked, >=1
// - CNT_WIDTH      32  width of the stall counter
// PORTS
// - CLK              in   1              clock; everything is on the rising edge
// - RST              in   1              synchronous reset, active-high
// - entry_pt_switch  in   1              restarts init traversal
// - thread_ready     in   N_THREADS      bit i=1: thread i is in THREAD_STATE_WR_RDY
// - thread_en        in   N_THREADS      bit i=0: thread i is never picked
// - NEXT_THREAD      in   1              current thread yields (1-cycle pulse)
// - RELOAD           out  1              combinational; thread_num changes on this edge
// - thread_num       out  N_THREADS_MSB+1  current thread, registered
// - thread_init      out  1              init traversal in progress
// - suspended        out  1              no thread is running
// - cycles_suspended out  CNT_WIDTH      count of cycles with suspended & ~thread_init
// BEHAVIOUR
// - Reset values (RST=1): thread_num=0, thread_init=1, suspended=1, cycles_suspended=0, hold-off history cleared.
// - Reset output: RELOAD=0 while thread_init=1.
// - Priority of control: RST > entry_pt_switch > init traversal > scheduling.
// - entry_pt_switch: next cycle thread_num=0, thread_init=1. suspended and cycles_suspended are unchanged.
// - Init traversal: thread_num steps 0,1,...,N_THREADS-1, one per cycle.
//   - On the edge leaving N_THREADS-1: thread_num<=0 and thread_init<=0.
//   - NEXT_THREAD and thread_ready are ignored during init.
// - eligible[i] = thread_ready[i] & thread_en[i].
// - Current thread (thread_num) is eligible only when it is eligible AND suspended has been 1 for the last TS_DELAY consecutive cycles.
// - Search order starts at thread_num+1, wraps modulo N_THREADS (N_THREADS-1 -> 0), and ends at thread_num.
// - pick = first eligible thread in search order; grant = any eligible.
// - RELOAD = ~thread_init & grant & (suspended | NEXT_THREAD).
// - On RELOAD: thread_num<=pick, suspended<=0. Latency is 1 cycle from ready to thread_num.
// - NEXT_THREAD & ~grant & ~thread_init: suspended<=1 and thread_num holds.
// - NEXT_THREAD while suspended: no extra effect beyond the RELOAD rule.
// - Otherwise thread_num and suspended hold.
// - Hold-off history: shift register fed by suspended. Any cycle with suspended=0 restarts the count.
// - cycles_suspended: +1 per cycle when suspended & ~thread_init; saturates at all-ones; cleared only by RST.
// - Inputs are assumed registered upstream; the pick path is combinational only within this block.
// TESTING
// - Reset + init, N_THREADS=6: RST 1 cycle -> thread_num 0..5 on consecutive cycles, then 0 with thread_init=0, suspended=1, RELOAD=0 throughout.
// - Wake from suspend: thread_ready=6'b001000 after init -> RELOAD=1 same cycle; next cycle thread_num=3, suspended=0.
// - Round-robin wrap: thread_num=4, ready=6'b010011, NEXT_THREAD -> thread_num=0; second NEXT_THREAD -> thread_num=1 (4 is skipped until re-readied).
// - Same-thread hold-off, TS_DELAY=2: ready=only thread_num=2, NEXT_THREAD -> suspended=1, no RELOAD for 2 cycles, RELOAD on 3rd cycle, thread_num=2.
// - Mask + stall count: ready=all-ones, thread_en=0, 10 cycles -> no RELOAD, cycles_suspended +10; CNT_WIDTH=4 -> saturates at 15.
// - Mid-operation: entry_pt_switch while thread_num=3 running -> next cycle thread_num=0, thread_init=1; RST mid-init -> all reset values next cycle.

Source files
------------

// File: rtl/thread_scheduler_rr_if.sv
// Signal bundle between a core and its round-robin thread scheduler.
// The core drives readiness and control; the scheduler returns the selected thread and status.
interface thread_scheduler_rr_if #(
  parameter int N_THREADS = 16,
  parameter int CNT_WIDTH = 32
);
  localparam int TW = $clog2(N_THREADS);

  // Handshake: NEXT_THREAD is a one-cycle yield request from the running thread.
  // RELOAD is combinational and marks the rising edge on which thread_num changes;
  // no ready/acknowledge is returned, the yield is always accepted.
  logic                 entry_pt_switch;
  logic [N_THREADS-1:0] thread_ready;
  logic [N_THREADS-1:0] thread_en;
  logic                 NEXT_THREAD;
  logic                 RELOAD;
  logic [TW-1:0]        thread_num;
  logic                 thread_init;
  logic                 suspended;
  logic [CNT_WIDTH-1:0] cycles_suspended;

  modport master (
    output entry_pt_switch, thread_ready, thread_en, NEXT_THREAD,
    input  RELOAD, thread_num, thread_init, suspended, cycles_suspended
  );

  modport slave (
    input  entry_pt_switch, thread_ready, thread_en, NEXT_THREAD,
    output RELOAD, thread_num, thread_init, suspended, cycles_suspended
  );
endinterface

// File: rtl/thread_scheduler_rr.sv
// Per-core round-robin thread scheduler: one-cycle pick of the next runnable thread,
// init traversal, same-thread hold-off and a saturating stall counter.
module thread_scheduler_rr #(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int TS_DELAY      = 2,
  parameter int CNT_WIDTH     = 32
) (
  input logic CLK,
  input logic RST,
  thread_scheduler_rr_if.slave bus
);
  localparam int TW = N_THREADS_MSB + 1;

  logic [TW-1:0]        thread_num;
  logic                 thread_init;
  logic                 suspended;
  logic [CNT_WIDTH-1:0] cycles_suspended;
  logic [TS_DELAY-1:0]  hist;

  logic [N_THREADS-1:0] elig;
  logic [TW-1:0]        pick;
  logic                 grant;
  logic                 reload;

  // Search starts one past the current thread and wraps; the current thread is last
  // and only counts once it has sat suspended for TS_DELAY full cycles.
  always_comb begin
    logic [TW-1:0] idx;
    elig  = bus.thread_ready & bus.thread_en;
    elig[thread_num] = elig[thread_num] & (&hist);
    pick  = thread_num;
    grant = 1'b0;
    idx   = thread_num;
    for (int k = 0; k < N_THREADS; k++) begin
      idx = (idx == TW'(N_THREADS - 1)) ? '0 : idx + 1'b1;
      if (!grant && elig[idx]) begin
        grant = 1'b1;
        pick  = idx;
      end
    end
    reload = ~thread_init & grant & (suspended | bus.NEXT_THREAD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      thread_num       <= '0;
      thread_init      <= 1'b1;
      suspended        <= 1'b1;
      cycles_suspended <= '0;
      hist             <= '0;
    end else begin
      hist <= (hist << 1) | TS_DELAY'(suspended);
      if (suspended && !thread_init && !(&cycles_suspended))
        cycles_suspended <= cycles_suspended + 1'b1;

      if (bus.entry_pt_switch) begin
        thread_num  <= '0;
        thread_init <= 1'b1;
      end else if (thread_init) begin
        if (thread_num == TW'(N_THREADS - 1)) begin
          thread_num  <= '0;
          thread_init <= 1'b0;
        end else begin
          thread_num <= thread_num + 1'b1;
        end
      end else if (reload) begin
        thread_num <= pick;
        suspended  <= 1'b0;
      end else if (bus.NEXT_THREAD && !grant) begin
        suspended <= 1'b1;
      end
    end
  end

  assign bus.RELOAD           = reload;
  assign bus.thread_num       = thread_num;
  assign bus.thread_init      = thread_init;
  assign bus.suspended        = suspended;
  assign bus.cycles_suspended = cycles_suspended;
endmodule

// File: tb/tb_thread_scheduler_rr.sv
// Bench for thread_scheduler_rr: directed scenarios plus random traffic, all checked
// against a behavioural scheduler model kept in this file.
module tb_thread_scheduler_rr;
  localparam int N  = 6;
  localparam int TD = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  thread_scheduler_rr_if #(.N_THREADS(N), .CNT_WIDTH(CW)) bus ();

  thread_scheduler_rr #(.N_THREADS(N), .TS_DELAY(TD), .CNT_WIDTH(CW)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  int m_num, m_cnt, m_run, m_pick;
  bit m_init, m_susp, m_grant, m_reload;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit e;
    int t;
    m_grant = 0;
    m_pick  = m_num;
    for (int k = 1; k <= N; k++) begin
      t = (m_num + k) % N;
      e = bus.thread_ready[t] && bus.thread_en[t];
      if (t == m_num && m_run < TD) e = 0;
      if (e && !m_grant) begin
        m_grant = 1;
        m_pick  = t;
      end
    end
    m_reload = !m_init && m_grant && (m_susp || bus.NEXT_THREAD);
  endtask

  task automatic model_update();
    if (rst) begin
      m_num = 0; m_init = 1; m_susp = 1; m_cnt = 0; m_run = 0;
    end else begin
      if (m_susp && !m_init && m_cnt < CMAX) m_cnt++;
      m_run = m_susp ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
      if (bus.entry_pt_switch) begin
        m_num = 0; m_init = 1;
      end else if (m_init) begin
        if (m_num == N - 1) begin m_num = 0; m_init = 0; end
        else m_num++;
      end else if (m_reload) begin
        m_num = m_pick; m_susp = 0;
      end else if (bus.NEXT_THREAD && !m_grant) begin
        m_susp = 1;
      end
    end
  endtask

  // one clock: compare against the model mid-cycle, advance the model on the edge
  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("reload", bus.RELOAD, m_reload);
    chk("thread_num", bus.thread_num, m_num);
    chk("thread_init", bus.thread_init, m_init);
    chk("suspended", bus.suspended, m_susp);
    chk("cycles_suspended", bus.cycles_suspended, m_cnt);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] rdy, input logic [N-1:0] en, input logic nxt);
    bus.thread_ready = rdy;
    bus.thread_en    = en;
    bus.NEXT_THREAD  = nxt;
  endtask

  int c0;

  initial begin
    n_tests = 0; n_fail = 0;
    m_num = 0; m_init = 1; m_susp = 1; m_cnt = 0; m_run = 0;
    rst = 1'b1;
    bus.entry_pt_switch = 1'b0;
    drive('0, '1, 1'b0);
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;

    // reset values and init traversal
    chk("rst_num", bus.thread_num, 0);
    chk("rst_init", bus.thread_init, 1);
    chk("rst_susp", bus.suspended, 1);
    chk("rst_cnt", bus.cycles_suspended, 0);
    chk("rst_reload", bus.RELOAD, 0);
    for (int i = 1; i < N; i++) begin
      cycle();
      chk("init_step", bus.thread_num, i);
    end
    cycle();
    chk("init_end_num", bus.thread_num, 0);
    chk("init_end_flag", bus.thread_init, 0);
    chk("init_end_susp", bus.suspended, 1);

    // wake from suspend
    drive(6'b001000, '1, 1'b0); #1;
    chk("wake_reload", bus.RELOAD, 1);
    cycle();
    chk("wake_num", bus.thread_num, 3);
    chk("wake_susp", bus.suspended, 0);

    // round-robin wrap
    drive(6'b010000, '1, 1'b1);
    cycle();
    chk("rr_to4", bus.thread_num, 4);
    drive(6'b010011, '1, 1'b1);
    cycle();
    chk("rr_wrap0", bus.thread_num, 0);
    cycle();
    chk("rr_next1", bus.thread_num, 1);

    // same-thread hold-off
    drive(6'b000100, '1, 1'b1);
    cycle();
    chk("ho_to2", bus.thread_num, 2);
    cycle();
    chk("ho_susp", bus.suspended, 1);
    chk("ho_num", bus.thread_num, 2);
    drive(6'b000100, '1, 1'b0); #1;
    chk("ho_wait1", bus.RELOAD, 0);
    cycle(); #1;
    chk("ho_wait2", bus.RELOAD, 0);
    cycle(); #1;
    chk("ho_reload", bus.RELOAD, 1);
    cycle();
    chk("ho_num2", bus.thread_num, 2);
    chk("ho_run", bus.suspended, 0);

    // mask and stall counter
    drive('1, '0, 1'b1);
    cycle();
    drive('1, '0, 1'b0);
    c0 = m_cnt;
    for (int i = 0; i < 10; i++) begin
      #1 chk("mask_reload", bus.RELOAD, 0);
      cycle();
    end
    chk("mask_cnt", bus.cycles_suspended, (c0 + 10 > CMAX) ? CMAX : c0 + 10);
    repeat (10) cycle();
    chk("cnt_sat", bus.cycles_suspended, CMAX);

    // entry point switch while running, then reset mid-init
    drive(6'b001000, '1, 1'b0);
    cycle();
    chk("mid_num3", bus.thread_num, 3);
    drive('0, '1, 1'b0);
    bus.entry_pt_switch = 1'b1;
    cycle();
    bus.entry_pt_switch = 1'b0;
    chk("eps_num", bus.thread_num, 0);
    chk("eps_init", bus.thread_init, 1);
    chk("eps_susp", bus.suspended, 0);
    cycle(); cycle();
    chk("eps_step", bus.thread_num, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mrst_num", bus.thread_num, 0);
    chk("mrst_init", bus.thread_init, 1);
    chk("mrst_susp", bus.suspended, 1);
    chk("mrst_cnt", bus.cycles_suspended, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.entry_pt_switch = ($urandom_range(0, 39) == 0);
      bus.thread_ready = N'($urandom);
      bus.thread_en    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      bus.NEXT_THREAD  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
